// File: rtl/chargen_pkg.sv
// Shared types and constants for the chargen burst controller and its bench.
package chargen_pkg;

   localparam int unsigned LEN_W   = 8;
   localparam int unsigned STALL_W = 16;
   localparam int unsigned CHAR_W  = 8;

   // Default character range of the chargen generator ("a" .. "c").
   localparam logic [CHAR_W-1:0] INITCHAR = 8'h61;
   localparam logic [CHAR_W-1:0] LASTCHAR = 8'h63;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/chargen_ctrl_if.sv
// Host, chargen and FIFO signals of the burst controller.
// Optional: CHARGEN_CTRL_STALL_CNT_EN adds the stall_cnt output.
interface chargen_ctrl_if;
   import chargen_pkg::*;

   logic              req;
   logic [LEN_W-1:0]  len;
   logic              abort;
   logic              busy;
   logic              done;
   logic [LEN_W-1:0]  count;
   logic              gen_n_cs;
   logic [CHAR_W-1:0] gen_data;
   logic              fifo_full;
   logic              fifo_n_wr;
   logic [CHAR_W-1:0] fifo_data;
`ifdef CHARGEN_CTRL_STALL_CNT_EN
   logic [STALL_W-1:0] stall_cnt;
`endif

   // Controller side.
   modport slave (
      input  req, len, abort, gen_data, fifo_full,
      output busy, done, count, gen_n_cs, fifo_n_wr, fifo_data
`ifdef CHARGEN_CTRL_STALL_CNT_EN
      , output stall_cnt
`endif
   );

   // Host / datapath side.
   modport master (
      output req, len, abort, gen_data, fifo_full,
      input  busy, done, count, gen_n_cs, fifo_n_wr, fifo_data
`ifdef CHARGEN_CTRL_STALL_CNT_EN
      , input stall_cnt
`endif
   );

endinterface

// File: rtl/chargen_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear.
module sat_cnt #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt_q
);

   localparam logic [W-1:0] MAX = '1;

   logic [W-1:0] cnt_d;

   // Clear wins over increment; increment stops at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != MAX)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/chargen_ctrl.sv
// Burst controller: moves N chargen characters into a write FIFO.
// Optional: CHARGEN_CTRL_STALL_CNT_EN counts WRITE cycles stalled by fifo_full.
module chargen_ctrl
   import chargen_pkg::*;
(
   input  logic           clk,
   input  logic           n_rst,
   chargen_ctrl_if.slave  bus
);

   state_e            state_q, state_d;
   logic [LEN_W-1:0]  remain_q, remain_d;
   logic              abort_q, abort_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic [CHAR_W-1:0] fifo_data_q, fifo_data_d;
   logic              accept_c;
   logic              wr_c;

   // Request acceptance and the actual write beat.
   always_comb begin
      accept_c = (state_q == ST_IDLE) && bus.req;
      wr_c     = (state_q == ST_WRITE) && !bus.fifo_full;
   end

   // Next-state, remaining length, abort latch and data capture.
   always_comb begin
      state_d     = state_q;
      remain_d    = remain_q;
      abort_d     = abort_q;
      fifo_data_d = fifo_data_q;
      if ((state_q != ST_IDLE) && bus.abort) abort_d = 1'b1;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.req) begin
               remain_d = bus.len;
               abort_d  = 1'b0;
               state_d  = (bus.len != '0) ? ST_LOAD : ST_DONE;
            end
         end
         ST_LOAD: begin
            fifo_data_d = bus.gen_data;
            state_d     = ST_WRITE;
         end
         ST_WRITE: begin
            if (!bus.fifo_full) begin
               remain_d = remain_q - LEN_W'(1);
               if ((remain_q == LEN_W'(1)) || abort_q || bus.abort) state_d = ST_DONE;
               else                                                  state_d = ST_LOAD;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
      done_d = (state_d == ST_DONE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q     <= ST_IDLE;
         remain_q    <= '0;
         abort_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         fifo_data_q <= '0;
      end else begin
         state_q     <= state_d;
         remain_q    <= remain_d;
         abort_q     <= abort_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         fifo_data_q <= fifo_data_d;
      end
   end

   // Strobes decode the registered state, gated by fifo_full in the same cycle.
   assign bus.gen_n_cs  = ~wr_c;
   assign bus.fifo_n_wr = ~wr_c;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.fifo_data = fifo_data_q;

   // Characters written in the current/last burst.
   sat_cnt #(.W(LEN_W)) u_count (
      .clk   (clk),
      .n_rst (n_rst),
      .clr   (accept_c),
      .inc   (wr_c),
      .cnt_q (bus.count)
   );

`ifdef CHARGEN_CTRL_STALL_CNT_EN
   logic stall_c;

   // A stalled beat: in WRITE with the FIFO full.
   always_comb stall_c = (state_q == ST_WRITE) && bus.fifo_full;

   sat_cnt #(.W(STALL_W)) u_stall (
      .clk   (clk),
      .n_rst (n_rst),
      .clr   (accept_c),
      .inc   (stall_c),
      .cnt_q (bus.stall_cnt)
   );
`endif

endmodule

// File: tb/tb_chargen_ctrl.sv
// Bench for chargen_ctrl: directed bursts, then randomized bursts with stalls and aborts.
module tb_chargen_ctrl;
   import chargen_pkg::*;

   localparam int unsigned NCH = 32'(LASTCHAR) - 32'(INITCHAR) + 32'd1;

   logic clk   = 1'b0;
   logic n_rst = 1'b1;
   int   compared   = 0;
   int   mismatched = 0;
   int   exp_idx    = 0;   // characters the FIFO has accepted so far

   chargen_ctrl_if bus ();

   chargen_ctrl dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Simple chargen: advances on n_cs low at the clock edge, wraps to INITCHAR.
   logic [7:0] gen_q = INITCHAR;
   always @(posedge clk) begin
      if (!bus.gen_n_cs) gen_q <= (gen_q == LASTCHAR) ? INITCHAR : gen_q + 8'd1;
   end
   assign bus.gen_data = gen_q;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_char(input int idx);
      return 32'(INITCHAR) + 32'(idx % NCH);
   endfunction

   // One burst with a precomputed stall schedule; timing derived from cycle arithmetic.
   task automatic run_burst(input int n, input int abort_k, input int abort_off,
                            input int stall_max, input int force_i, input int force_s);
      int stalls [64];
      int load_c [64];
      int wr_cyc [64];
      int w, d, t, total_st, abort_c, off, exp_cnt;
      logic is_wr, is_st;
      w = (abort_k > 0 && abort_k <= n) ? abort_k : n;
      t = 1;
      total_st = 0;
      for (int i = 1; i <= w; i++) begin
         stalls[i] = (i == force_i) ? force_s : int'($urandom_range(stall_max, 0));
         load_c[i] = t;
         wr_cyc[i] = t + 1 + stalls[i];
         t = wr_cyc[i] + 1;
         total_st += stalls[i];
      end
      d = (w == 0) ? 1 : t;
      abort_c = -1;
      if (abort_k > 0 && abort_k <= n) begin
         off = (abort_off > stalls[abort_k] + 1) ? stalls[abort_k] + 1 : abort_off;
         abort_c = load_c[abort_k] + off;
      end
      // request sampled at the next edge (edge 0); abort here is in IDLE and ignored
      @(posedge clk); #1;
      bus.req       = 1'b1;
      bus.len       = LEN_W'(n);
      bus.fifo_full = 1'($urandom);
      bus.abort     = 1'($urandom);
      exp_cnt = 0;
      for (int c = 1; c <= d + 1; c++) begin
         @(posedge clk); #1;
         is_wr = 1'b0;
         is_st = 1'b0;
         for (int i = 1; i <= w; i++) begin
            if (c == wr_cyc[i]) is_wr = 1'b1;
            if (c > load_c[i] && c < wr_cyc[i]) is_st = 1'b1;
         end
         bus.req       = (c <= d) ? 1'($urandom) : 1'b0;
         bus.len       = LEN_W'($urandom);
         bus.fifo_full = is_st ? 1'b1 : (is_wr ? 1'b0 : 1'($urandom));
         bus.abort     = (c == abort_c) ? 1'b1 : ((c >= d) ? 1'($urandom) : 1'b0);
         @(negedge clk);
         check("fifo_n_wr", 32'(bus.fifo_n_wr), 32'(!is_wr));
         check("gen_n_cs",  32'(bus.gen_n_cs),  32'(!is_wr));
         check("done",      32'(bus.done),      32'(c == d));
         check("busy",      32'(bus.busy),      32'(c <= d));
         check("count",     32'(bus.count),     32'(exp_cnt));
         if (is_wr) begin
            check("fifo_data", 32'(bus.fifo_data), exp_char(exp_idx));
            exp_idx++;
            exp_cnt++;
         end
      end
      bus.abort = 1'b0;
      check("final_count", 32'(bus.count), 32'(w));
`ifdef CHARGEN_CTRL_STALL_CNT_EN
      check("stall_cnt", 32'(bus.stall_cnt), 32'(total_st));
`endif
   endtask

   initial begin
      int n, ak;
      bus.req       = 1'b0;
      bus.len       = '0;
      bus.abort     = 1'b0;
      bus.fifo_full = 1'b0;

      // Asynchronous reset takes effect before any clock edge.
      #2 n_rst = 1'b0;
      #1;
      check("rst_gen_n_cs",  32'(bus.gen_n_cs),  32'd1);
      check("rst_fifo_n_wr", 32'(bus.fifo_n_wr), 32'd1);
      check("rst_busy",      32'(bus.busy),      32'd0);
      check("rst_done",      32'(bus.done),      32'd0);
      check("rst_count",     32'(bus.count),     32'd0);
      check("rst_fifo_data", 32'(bus.fifo_data), 32'd0);
`ifdef CHARGEN_CTRL_STALL_CNT_EN
      check("rst_stall_cnt", 32'(bus.stall_cnt), 32'd0);
`endif
      repeat (3) @(posedge clk);
      #1 n_rst = 1'b1;

      // Directed: a,b,c,a,b then c; stalled burst; empty burst; aborted burst.
      run_burst(5, 0, 0, 0, 0, 0);
      run_burst(1, 0, 0, 0, 0, 0);
      run_burst(4, 0, 0, 0, 2, 3);
      run_burst(0, 0, 0, 0, 0, 0);
      run_burst(10, 3, 0, 0, 0, 0);

      // Reset during the second WRITE of a 5-character burst.
      @(posedge clk); #1;
      bus.req = 1'b1; bus.len = LEN_W'(5); bus.fifo_full = 1'b0;
      @(posedge clk); #1;
      bus.req = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("rst_burst_wr1", 32'(bus.fifo_n_wr), 32'd0);
      check("rst_burst_d1",  32'(bus.fifo_data), exp_char(exp_idx));
      exp_idx++;
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_rst = 1'b0;
      #1;
      check("midrst_fifo_n_wr", 32'(bus.fifo_n_wr), 32'd1);
      check("midrst_gen_n_cs",  32'(bus.gen_n_cs),  32'd1);
      check("midrst_busy",      32'(bus.busy),      32'd0);
      check("midrst_done",      32'(bus.done),      32'd0);
      check("midrst_count",     32'(bus.count),     32'd0);
      check("midrst_fifo_data", 32'(bus.fifo_data), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("inrst_fifo_n_wr", 32'(bus.fifo_n_wr), 32'd1);
      end
      @(posedge clk); #1 n_rst = 1'b1;
      run_burst(3, 0, 0, 1, 0, 0);

      // Randomized bursts with stalls and occasional aborts.
      for (int k = 0; k < 20; k++) begin
         n  = int'($urandom_range(12, 0));
         ak = ($urandom_range(3, 0) == 0 && n > 0) ? int'($urandom_range(n, 1)) : 0;
         run_burst(n, ak, int'($urandom_range(4, 0)), 3, 0, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
